mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports if_req_i  in  1, if_addr_i  in  ADDR_W: instruction-fetch request and address.
REQ-006 SHALL have ports if_rdata_o  out  DATA_W, if_ready_o  out  1: fetched word and one-cycle completion pulse.
REQ-007 SHALL have ports d_req_i  in  1, d_we_i  in  1, d_addr_i  in  ADDR_W, d_wdata_i  in  DATA_W: data-stage request.
REQ-008 SHALL have ports d_rdata_o  out  DATA_W, d_ready_o  out  1: load data and one-cycle completion pulse.
REQ-009 SHALL have ports mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  ADDR_W, mem_wdata_o  out  DATA_W: shared memory port.
REQ-010 SHALL have ports mem_rdata_i  in  DATA_W, mem_ack_i  in  1: memory read data and completion.
REQ-011 SHALL have port stall_o  out  1: pipeline freeze (drives PC write-disable and IF/ID hold).

Function
REQ-012 SHALL implement states IDLE, BUSY_I, BUSY_D, RESP.
REQ-013 IDLE: d_req_i=1 -> latch d_we/d_addr/d_wdata, go BUSY_D; else if_req_i=1 -> latch if_addr, go BUSY_I; else stay.
REQ-014 BUSY_x: mem_req_o=1 with latched we/addr/wdata held stable until mem_ack_i=1; then capture mem_rdata_i, go RESP.
REQ-015 mem_we_o SHALL be 0 in BUSY_I; mem_req_o SHALL be 0 in IDLE and RESP.
REQ-016 RESP: pulse the served port's ready for exactly one cycle, go IDLE; requests are not sampled in RESP.
REQ-017 Minimum latency: request seen in IDLE at cycle N, ack at N+1 -> ready at N+2.
REQ-018 if_rdata_o/d_rdata_o SHALL hold their value until the next completed read on that port; a data write SHALL not update d_rdata_o.
REQ-019 stall_o = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o), combinational.
REQ-020 mem_ack_i outside BUSY_x SHALL be ignored; requester inputs changing while BUSY_x SHALL not affect the memory port.
REQ-021 Requesters hold req until ready; a req still high in the cycle after ready is a new request.

Reset
REQ-022 rst_n_i=0 at an edge SHALL force IDLE, mem_req_o=0, mem_we_o=0, ready outputs 0, rdata/addr/wdata registers 0.
REQ-023 Reset mid-access SHALL abandon the transaction; a later mem_ack_i SHALL be ignored and produce no ready pulse.

Configuration
REQ-024 With MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL grant the port not served last (last-served flag resets to fetch, so data wins first).
REQ-025 Without MEM_ARB_RR_EN, simultaneous requests SHALL always grant data; no last-served flag exists.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and port-id constants (PORT_I, PORT_D).
REQ-027 One sub-module mem_arb_req_latch (enable-loaded we/addr/wdata register) is natural; the FSM stays in mem_arbiter.

Verification
REQ-028 Fetch alone: if_req=1, addr 0x0000_0010, ack next cycle, rdata 0x2002_0005 -> if_ready pulse at cycle+2, if_rdata=0x2002_0005, stall_o high for 2 cycles.
REQ-029 Collision: if_req and d_req (load 0x0000_0040) in same cycle -> data served first, fetch granted after RESP; with MEM_ARB_RR_EN a second collision serves fetch first.
REQ-030 Store: d_we=1, addr 0x8, wdata 0xDEAD_BEEF, ack delayed 3 cycles -> mem_we/addr/wdata stable 4 cycles, d_ready pulse once, d_rdata unchanged.
REQ-031 Reset mid-access: rst_n_i=0 during BUSY_D, ack arrives after release -> no ready pulse, mem_req_o=0, state IDLE.
REQ-032 Spurious ack: mem_ack_i=1 in IDLE with no request -> no ready pulse, rdata outputs unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Port ids name the requester being served.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } arb_state_e;

endpackage

// File: rtl/mem_arb_req_latch.sv
// Enable-loaded request register; holds we/addr/wdata
// stable on the memory port for the whole access.
module mem_arb_req_latch
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o
);

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (load_i) begin
         we_q    <= we_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data stages.
// MEM_ARB_RR_EN: alternate winner on simultaneous requests.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o
);

   arb_state_e        state_q, state_d;
   logic              port_q, port_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              load;
   logic              pick_data;
   logic              lat_we;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // On a collision, serve whichever port lost the previous one
   assign pick_data = (if_req_i & d_req_i) ? (last_q == PORT_I)
                                           : d_req_i;
`else
   assign pick_data = d_req_i;
`endif

   mem_arb_req_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_latch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load),
      .we_i    (pick_data & d_we_i),
      .addr_i  (pick_data ? d_addr_i : if_addr_i),
      .wdata_i (pick_data ? d_wdata_i : '0),
      .we_o    (lat_we),
      .addr_o  (mem_addr_o),
      .wdata_o (mem_wdata_o)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         port_q     <= PORT_I;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         last_q <= PORT_I;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      load       = 1'b0;
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      if_ready_o = 1'b0;
      d_ready_o  = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (d_req_i | if_req_i) begin
               load    = 1'b1;
               port_d  = pick_data ? PORT_D : PORT_I;
               state_d = pick_data ? BUSY_D : BUSY_I;
`ifdef MEM_ARB_RR_EN
               if (if_req_i & d_req_i) begin
                  last_d = pick_data ? PORT_D : PORT_I;
               end
`endif
            end
         end
         BUSY_I: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               if_rdata_d = mem_rdata_i;
               state_d    = RESP;
            end
         end
         BUSY_D: begin
            mem_req_o = 1'b1;
            mem_we_o  = lat_we;
            if (mem_ack_i) begin
               if (!lat_we) begin
                  d_rdata_d = mem_rdata_i;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if_ready_o = (port_q == PORT_I);
            d_ready_o  = (port_q == PORT_D);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_rdata_o = if_rdata_q;
   assign d_rdata_o  = d_rdata_q;
   assign stall_o    = (if_req_i & ~if_ready_o)
                     | (d_req_i & ~d_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Expected values are hand-computed per scenario.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;
   logic rr;
   logic [31:0] if_exp;
   logic [31:0] d_exp;

   mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_rdata_o  (if_rdata),
      .if_ready_o  (if_ready),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_rdata_o   (d_rdata),
      .d_ready_o   (d_ready),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (mem_ack),
      .stall_o     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef MEM_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      rst_n = 0; if_req = 0; if_addr = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      tick();
      tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_if_ready", if_ready, 0);
      check("rst_d_ready", d_ready, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst_n = 1;

      // fetch alone
      if_req = 1; if_addr = 32'h10;
      #1 check("f_stall0", stall, 1);
      tick();
      check("f_mem_req", mem_req, 1);
      check("f_mem_addr", mem_addr, 32'h10);
      check("f_mem_we", mem_we, 0);
      check("f_stall1", stall, 1);
      check("f_no_ready", if_ready, 0);
      mem_ack = 1; mem_rdata = 32'h2002_0005;
      tick();
      check("f_if_ready", if_ready, 1);
      check("f_d_ready", d_ready, 0);
      check("f_if_rdata", if_rdata, 32'h2002_0005);
      check("f_stall2", stall, 0);
      check("f_req_resp", mem_req, 0);
      if_req = 0; mem_ack = 0;
      tick();
      check("f_ready_once", if_ready, 0);

      // collision: data first, then fetch
      if_req = 1; if_addr = 32'h100;
      d_req = 1; d_we = 0; d_addr = 32'h40;
      tick();
      check("c_addr", mem_addr, 32'h40);
      check("c_we", mem_we, 0);
      mem_ack = 1; mem_rdata = 32'h1111_2222;
      tick();
      check("c_d_ready", d_ready, 1);
      check("c_if_ready", if_ready, 0);
      check("c_d_rdata", d_rdata, 32'h1111_2222);
      check("c_if_hold", if_rdata, 32'h2002_0005);
      check("c_stall", stall, 1);
      d_req = 0; mem_ack = 0;
      tick();
      check("c_idle_req", mem_req, 0);
      tick();
      check("c_f_req", mem_req, 1);
      check("c_f_addr", mem_addr, 32'h100);
      mem_ack = 1; mem_rdata = 32'h3333_4444;
      tick();
      check("c_f_ready", if_ready, 1);
      check("c_f_rdata", if_rdata, 32'h3333_4444);
      if_req = 0; mem_ack = 0;
      tick();
      if_exp = 32'h3333_4444;
      d_exp  = 32'h1111_2222;

      // second collision: fetch wins only with round-robin
      if_req = 1; if_addr = 32'h200;
      d_req = 1; d_addr = 32'h44;
      tick();
      check("c2_addr", mem_addr, rr ? 32'h200 : 32'h44);
      mem_ack = 1; mem_rdata = 32'h5555_6666;
      tick();
      check("c2_if_ready", if_ready, rr);
      check("c2_d_ready", d_ready, !rr);
      if (rr) if_exp = 32'h5555_6666;
      else d_exp = 32'h5555_6666;
      check("c2_if_rdata", if_rdata, if_exp);
      check("c2_d_rdata", d_rdata, d_exp);
      if_req = 0; d_req = 0; mem_ack = 0;
      tick();

      // store with ack after 3 wait cycles; inputs wiggle meanwhile
      d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
      tick();
      d_we = 0; d_addr = 32'h99; d_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         check("s_req", mem_req, 1);
         check("s_we", mem_we, 1);
         check("s_addr", mem_addr, 32'h8);
         check("s_wdata", mem_wdata, 32'hDEAD_BEEF);
         check("s_no_ready", d_ready, 0);
         if (i == 3) begin
            mem_ack = 1; mem_rdata = 32'h7777_7777;
         end
         tick();
      end
      check("s_d_ready", d_ready, 1);
      check("s_d_rdata", d_rdata, d_exp);
      d_req = 0; mem_ack = 0;
      tick();
      check("s_ready_once", d_ready, 0);
      check("s_rdata_hold", d_rdata, d_exp);

      // reset while busy; late ack must be ignored
      d_req = 1; d_we = 0; d_addr = 32'h20;
      tick();
      check("r_busy", mem_req, 1);
      rst_n = 0; d_req = 0;
      tick();
      rst_n = 1;
      mem_ack = 1; mem_rdata = 32'hAAAA_5555;
      check("r_req_off", mem_req, 0);
      check("r_we_off", mem_we, 0);
      tick();
      check("r_d_ready", d_ready, 0);
      check("r_if_ready", if_ready, 0);
      check("r_req_idle", mem_req, 0);
      mem_ack = 0;
      tick();
      check("r_d_ready2", d_ready, 0);
      check("r_d_rdata", d_rdata, 0);
      check("r_if_rdata", if_rdata, 0);

      // spurious ack in idle
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      check("sp_if_ready", if_ready, 0);
      check("sp_d_ready", d_ready, 0);
      check("sp_req", mem_req, 0);
      check("sp_if_rdata", if_rdata, 0);
      check("sp_d_rdata", d_rdata, 0);
      mem_ack = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
